// File: rtl/d_hazard_scoreboard.sv
// Decode-stage hazard unit: Tnew scoreboard, D stall, D-level forwarding selects, MDU busy interlock.
// Latency: outputs combinational from registered scoreboard and current D inputs; state advances every clk.
// Backpressure: raises stall to freeze F/D and inject an E bubble; HAZARD_FWD_EN enables forwarding selects.
module d_hazard_scoreboard #(
  parameter int STAGES  = 3,
  parameter int TNEW_W  = 2,
  parameter int MUL_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           D_valid,
  input  logic [4:0]                     D_rs,
  input  logic [4:0]                     D_rt,
  input  logic [1:0]                     D_Tuse_rs,
  input  logic [1:0]                     D_Tuse_rt,
  input  logic [4:0]                     D_A3,
  input  logic [TNEW_W-1:0]              D_Tnew,
  input  logic                           D_HILO_operation,
  input  logic                           D_md_start,
  input  logic                           D_md_div,
  input  logic                           flush,
  output logic                           stall,
  output logic [$clog2(STAGES+1)-1:0]    fwd_sel_rs,
  output logic [$clog2(STAGES+1)-1:0]    fwd_sel_rt,
  output logic                           md_busy
);

  localparam int SEL_W  = $clog2(STAGES + 1);
  localparam int MD_MAX = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
  localparam int CNT_W  = $clog2(MD_MAX + 1);

  logic              r_vld  [STAGES];
  logic [4:0]        r_a3   [STAGES];
  logic [TNEW_W-1:0] r_tnew [STAGES];
  logic [CNT_W-1:0]  r_md_cnt;

  logic [4:0]        w_src   [2];
  logic              w_hit   [2];
  logic [SEL_W-1:0]  w_idx   [2];
  logic [TNEW_W-1:0] w_mtnew [2];
  logic              w_haz   [2];
  logic [SEL_W-1:0]  w_fwd   [2];
  logic              w_issue;

  assign w_src[0] = D_rs;
  assign w_src[1] = D_rt;

  // Scan oldest to youngest so the lowest matching index wins.
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      w_hit[j]   = 1'b0;
      w_idx[j]   = '0;
      w_mtnew[j] = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
        if ((w_src[j] != 5'd0) && r_vld[k] && (r_a3[k] == w_src[j])) begin
          w_hit[j]   = 1'b1;
          w_idx[j]   = SEL_W'(k);
          w_mtnew[j] = r_tnew[k];
        end
      end
    end
  end

`ifdef HAZARD_FWD_EN
  localparam int CMP_W = (TNEW_W > 2) ? TNEW_W : 2;
  logic [1:0] w_tuse [2];
  assign w_tuse[0] = D_Tuse_rs;
  assign w_tuse[1] = D_Tuse_rt;

  always_comb begin
    for (int j = 0; j < 2; j++) begin
      w_haz[j] = w_hit[j] && (CMP_W'(w_mtnew[j]) > CMP_W'(w_tuse[j]));
      w_fwd[j] = '0;
      if (w_hit[j] && (w_mtnew[j] == '0))
        w_fwd[j] = w_idx[j] + SEL_W'(1);
    end
  end
`else
  // Without bypass only the W entry is safe to read, through register-file write-through.
  logic w_unused_tuse;
  assign w_unused_tuse = ^{D_Tuse_rs, D_Tuse_rt};

  always_comb begin
    for (int j = 0; j < 2; j++) begin
      w_haz[j] = w_hit[j] && ((w_idx[j] != SEL_W'(STAGES - 1)) || (w_mtnew[j] != '0));
      w_fwd[j] = '0;
    end
  end
`endif

  assign md_busy    = (r_md_cnt != '0);
  assign stall      = D_valid & (w_haz[0] | w_haz[1] | (D_HILO_operation & md_busy));
  assign fwd_sel_rs = w_fwd[0];
  assign fwd_sel_rt = w_fwd[1];
  assign w_issue    = D_valid & ~stall & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k]  <= 1'b0;
        r_a3[k]   <= '0;
        r_tnew[k] <= '0;
      end
      r_md_cnt <= '0;
    end else begin
      r_vld[0]  <= w_issue & (D_A3 != 5'd0);
      r_a3[0]   <= D_A3;
      r_tnew[0] <= D_Tnew;
      for (int k = 1; k < STAGES; k++) begin
        r_vld[k]  <= r_vld[k-1] & ~flush;
        r_a3[k]   <= r_a3[k-1];
        r_tnew[k] <= (r_tnew[k-1] == '0) ? '0 : r_tnew[k-1] - TNEW_W'(1);
      end
      // A flushed mult/div never started, so the counter only loads on a surviving issue.
      if (w_issue & D_md_start)
        r_md_cnt <= D_md_div ? CNT_W'(DIV_CYC) : CNT_W'(MUL_CYC);
      else if (r_md_cnt != '0)
        r_md_cnt <= r_md_cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_d_hazard_scoreboard.sv
// Bench for d_hazard_scoreboard: issue-history model checked every cycle plus directed pipeline scenarios.
module tb_d_hazard_scoreboard;

  localparam int STAGES  = 3;
  localparam int TNEW_W  = 2;
  localparam int MUL_CYC = 5;
  localparam int DIV_CYC = 10;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] urs;
    logic [1:0] urt;
    logic [4:0] a3;
    logic [1:0] tn;
    logic       hilo;
    logic       mds;
    logic       mdd;
    logic       fl;
  } dv_t;

  localparam dv_t BUB = '0;

  logic        clk, reset;
  logic        D_valid, D_HILO_operation, D_md_start, D_md_div, flush;
  logic [4:0]  D_rs, D_rt, D_A3;
  logic [1:0]  D_Tuse_rs, D_Tuse_rt;
  logic [TNEW_W-1:0] D_Tnew;
  logic        stall, md_busy;
  logic [1:0]  fwd_sel_rs, fwd_sel_rt;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   md_end = -1;
  bit   hv  [0:2047];
  int   ha3 [0:2047];
  int   htn [0:2047];

  logic       lit_vld = 1'b0;
  string      lit_nm  = "";
  logic       lit_stall, lit_busy;
  logic [1:0] lit_fwd;

  d_hazard_scoreboard #(
    .STAGES(STAGES), .TNEW_W(TNEW_W), .MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)
  ) dut (
    .clk(clk), .reset(reset), .D_valid(D_valid), .D_rs(D_rs), .D_rt(D_rt),
    .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt), .D_A3(D_A3), .D_Tnew(D_Tnew),
    .D_HILO_operation(D_HILO_operation), .D_md_start(D_md_start), .D_md_div(D_md_div),
    .flush(flush), .stall(stall), .fwd_sel_rs(fwd_sel_rs), .fwd_sel_rt(fwd_sel_rt),
    .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d cyc=%0d", nm, got, exp, cyc);
    end
  endtask

  // An instruction issued at cycle c sits k stages past D at cycle c+1+k with Tnew reduced by k.
  function automatic void lookup(input int s, output bit hit, output int k, output int tn);
    int c;
    hit = 0; k = 0; tn = 0;
    for (int kk = STAGES - 1; kk >= 0; kk--) begin
      c = cyc - 1 - kk;
      if (s != 0 && c >= 0 && hv[c] && ha3[c] == s) begin
        hit = 1;
        k   = kk;
        tn  = (htn[c] > kk) ? htn[c] - kk : 0;
      end
    end
  endfunction

  function automatic bit src_haz(input int s, input int tuse);
    bit h; int k, tn;
    lookup(s, h, k, tn);
    if (FWD) return h && (tn > tuse);
    return h && (k != STAGES - 1 || tn != 0);
  endfunction

  function automatic int src_fwd(input int s);
    bit h; int k, tn;
    lookup(s, h, k, tn);
    if (FWD && h && tn == 0) return k + 1;
    return 0;
  endfunction

  always @(negedge clk) begin : cmp
    bit es, eb;
    int ef_rs, ef_rt;
    if (!reset) begin
      for (int c = 0; c <= cyc && c < 2048; c++) hv[c] = 0;
      md_end = -1;
      chk("rst_stall", stall, 0);
      chk("rst_busy", md_busy, 0);
      chk("rst_fwd_rs", fwd_sel_rs, 0);
      chk("rst_fwd_rt", fwd_sel_rt, 0);
    end else begin
      eb    = (cyc <= md_end);
      es    = D_valid && (src_haz(D_rs, D_Tuse_rs) || src_haz(D_rt, D_Tuse_rt) ||
                          (D_HILO_operation && eb));
      ef_rs = src_fwd(D_rs);
      ef_rt = src_fwd(D_rt);
      chk("model_stall", stall, es);
      chk("model_busy", md_busy, eb);
      chk("model_fwd_rs", fwd_sel_rs, ef_rs);
      chk("model_fwd_rt", fwd_sel_rt, ef_rt);
      if (lit_vld) begin
        chk({lit_nm, "_stall"}, stall, lit_stall);
        chk({lit_nm, "_fwd_rs"}, fwd_sel_rs, lit_fwd);
        chk({lit_nm, "_busy"}, md_busy, lit_busy);
      end
      if (flush) begin
        for (int c = 0; c <= cyc; c++) hv[c] = 0;
      end else begin
        hv[cyc]  = D_valid && !es && D_A3 != 0;
        ha3[cyc] = D_A3;
        htn[cyc] = D_Tnew;
        if (D_valid && !es && D_md_start)
          md_end = cyc + (D_md_div ? DIV_CYC : MUL_CYC);
      end
    end
    cyc++;
  end

  function automatic dv_t ins(input int rs, input int rt, input int urs, input int urt,
                              input int a3, input int tn);
    dv_t d;
    d     = '0;
    d.v   = 1'b1;
    d.rs  = rs[4:0];
    d.rt  = rt[4:0];
    d.urs = urs[1:0];
    d.urt = urt[1:0];
    d.a3  = a3[4:0];
    d.tn  = tn[1:0];
    return d;
  endfunction

  task automatic drive(input dv_t d);
    @(posedge clk);
    #1;
    D_valid = d.v; D_rs = d.rs; D_rt = d.rt; D_Tuse_rs = d.urs; D_Tuse_rt = d.urt;
    D_A3 = d.a3; D_Tnew = d.tn; D_HILO_operation = d.hilo; D_md_start = d.mds;
    D_md_div = d.mdd; flush = d.fl;
    lit_vld = 1'b0;
  endtask

  task automatic expect_lit(input string nm, input logic s, input logic [1:0] f, input logic b);
    lit_nm = nm; lit_stall = s; lit_fwd = f; lit_busy = b; lit_vld = 1'b1;
  endtask

  task automatic issue_dep(input string nm, input dv_t d, input int nstall,
                           input logic [1:0] fwd_after, input logic busy_st);
    for (int i = 0; i < nstall; i++) begin
      drive(d);
      expect_lit(nm, 1'b1, 2'd0, busy_st);
    end
    drive(d);
    expect_lit(nm, 1'b0, fwd_after, 1'b0);
  endtask

  task automatic drain();
    repeat (3) drive(BUB);
  endtask

  initial begin : stim
    dv_t lw1, m, mf, d;
    reset = 1'b0;
    D_valid = 1'b1; D_rs = 5'd1; D_rt = 5'd1; D_Tuse_rs = 2'd0; D_Tuse_rt = 2'd0;
    D_A3 = 5'd0; D_Tnew = 2'd0; D_HILO_operation = 1'b1; D_md_start = 1'b0;
    D_md_div = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    lw1 = ins(29, 0, 1, 2, 1, 2);
    drive(lw1);
    expect_lit("lw_a", 1'b0, 2'd0, 1'b0);
    issue_dep("lw_use", ins(1, 3, 1, 1, 2, 1), FWD ? 1 : 2, 2'd0, 1'b0);
    drain();

    drive(lw1);
    issue_dep("lw_beq", ins(1, 4, 0, 0, 0, 0), 2, FWD ? 2'd3 : 2'd0, 1'b0);
    drain();

    drive(ins(6, 7, 1, 1, 5, 1));
    issue_dep("add_jr", ins(5, 0, 0, 2, 0, 0), FWD ? 1 : 2, FWD ? 2'd2 : 2'd0, 1'b0);
    drain();

    drive(ins(6, 7, 1, 1, 5, 1));
    drive(ins(8, 0, 1, 2, 5, 1));
    drive(BUB);
    issue_dep("youngest", ins(5, 0, 1, 2, 9, 1), FWD ? 0 : 1, FWD ? 2'd2 : 2'd0, 1'b0);
    drain();

    drive(ins(0, 0, 2, 2, 11, 3));
    issue_dep("tnew3", ins(11, 0, 1, 2, 12, 1), FWD ? 2 : 3, 2'd0, 1'b0);
    drain();

    m = ins(8, 9, 1, 1, 0, 0);
    m.hilo = 1'b1; m.mds = 1'b1;
    mf = ins(0, 0, 2, 2, 10, 1);
    mf.hilo = 1'b1;
    drive(m);
    expect_lit("mult", 1'b0, 2'd0, 1'b0);
    issue_dep("mflo_mul", mf, MUL_CYC, 2'd0, 1'b1);
    drain();
    d = m; d.mdd = 1'b1;
    drive(d);
    issue_dep("mflo_div", mf, DIV_CYC, 2'd0, 1'b1);
    drain();

    drive(ins(3, 0, 1, 2, 0, 1));
    issue_dep("zero_reg", ins(0, 0, 0, 0, 13, 1), 0, 2'd0, 1'b0);
    drain();

    drive(lw1);
    d = BUB; d.fl = 1'b1;
    drive(d);
    issue_dep("flush_e", ins(1, 0, 0, 2, 0, 0), 0, 2'd0, 1'b0);
    drain();
    d = lw1; d.fl = 1'b1;
    drive(d);
    issue_dep("flush_d", ins(1, 0, 0, 2, 0, 0), 0, 2'd0, 1'b0);
    drain();
    d = m; d.fl = 1'b1;
    drive(d);
    issue_dep("flush_md", mf, 0, 2'd0, 1'b0);
    drain();

    drive(m);
    drive(lw1);
    d = ins(1, 0, 0, 2, 2, 1);
    drive(d);
    expect_lit("pend", 1'b1, 2'd0, 1'b1);
    drive(d);
    #1 reset = 1'b0;
    drive(d);
    reset = 1'b1;
    expect_lit("post_rst", 1'b0, 2'd0, 1'b0);
    drain();

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
